// File: rtl/booth_multiplier_pkg.sv
// booth_multiplier_pkg
// Shared definitions for the sequential Booth multiplier:
//   - FSM state encodings (state_t)
//   - Booth step operation encodings (booth_op_t)
//   - operand width and number of Booth steps
package booth_multiplier_pkg;

  localparam int MULT_WIDTH = 32;
  localparam int MULT_STEPS = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_NOP = 2'd0,
    OP_ADD = 2'd1,
    OP_SUB = 2'd2
  } booth_op_t;

endpackage

// File: rtl/booth_multiplier_step_decode.sv
// booth_step_decode
// Combinational radix-2 Booth recoder.
// Ports:
//   pair   : {lo[0], q} of the product register
//   op     : selected Booth operation
//   b_inv  : select ~M as the adder B operand (subtract)
//   c0     : adder carry in (1 for subtract, completing two's complement)
//   add_en : the adder result is used this step
module booth_step_decode
  import booth_multiplier_pkg::*;
(
  input  logic [1:0] pair,
  output booth_op_t  op,
  output logic       b_inv,
  output logic       c0,
  output logic       add_en
);

  always_comb begin
    op = OP_NOP;
    case (pair)
      2'b01:   op = OP_ADD;
      2'b10:   op = OP_SUB;
      default: op = OP_NOP;
    endcase
    b_inv  = (op == OP_SUB);
    c0     = (op == OP_SUB);
    add_en = (op != OP_NOP);
  end

endmodule

// File: rtl/two_level_carry_lookahead.sv
// two_level_carry_lookahead
// The ALU's 32-bit adder: 4-bit carry-lookahead groups, with a second
// lookahead level producing the carry into each group.
// Ports:
//   a, b  : 32-bit addends
//   c0    : carry in
//   sum   : 32-bit sum
//   c32   : carry out of bit 31
module two_level_carry_lookahead (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        c0,
  output logic [31:0] sum,
  output logic        c32
);

  logic [31:0] g;
  logic [31:0] p;
  logic [31:0] c;
  logic [7:0]  gg;
  logic [7:0]  gp;
  logic [8:0]  gc;

  always_comb begin
    g = a & b;
    p = a ^ b;
    // First level: group generate / propagate per 4-bit group.
    for (int k = 0; k < 8; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
    end
    // Second level: carry into each group.
    gc[0] = c0;
    for (int k = 0; k < 8; k++) begin
      gc[k+1] = gg[k] | (gp[k] & gc[k]);
    end
    // Carries inside each group from the group carry-in.
    for (int k = 0; k < 8; k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k]   | (p[4*k]   & gc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])   | (p[4*k+1] & p[4*k]   & gc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end
    sum = p ^ c;
    c32 = gc[8];
  end

endmodule

// File: rtl/booth_multiplier.sv
// booth_multiplier
// Sequential 32x32 signed radix-2 Booth multiplier, one step per clock,
// using the ALU's two_level_carry_lookahead adder for every add/subtract.
// Handshake: ctrl_MULT is a start strobe sampled only in IDLE (ignored while
// busy); data_resultRDY pulses for exactly one cycle when data_result and
// data_exception become valid, and both are held until the next completion.
// Ports:
//   clock, reset     : clock, asynchronous active-high reset
//   data_operandA/B  : signed multiplicand / multiplier, sampled on start
//   ctrl_MULT        : start strobe
//   data_result      : low 32 bits of the product
//   data_exception   : product does not fit in signed 32 bits
//   data_resultRDY   : one-cycle result-valid pulse
//   busy             : high in RUN and DONE
//   dbg_state        : current FSM state
// Optional build macro BOOTH_EARLY_EXIT_EN: finish with one arithmetic shift
// once the remaining multiplier bits (and q) are all equal.
module booth_multiplier
  import booth_multiplier_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, m_q, m_d;
  logic               q_q, q_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               exc_q, exc_d, rdy_q, rdy_d;

  booth_op_t          op;
  logic               b_inv, c0, add_en, c32, sum_msb, early_exit;
  logic [WIDTH-1:0]   adder_b, adder_sum, step_sum;
  logic [2*WIDTH:0]   step_prod;

  booth_step_decode u_decode (
    .pair   ({lo_q[0], q_q}),
    .op     (op),
    .b_inv  (b_inv),
    .c0     (c0),
    .add_en (add_en)
  );

  two_level_carry_lookahead u_adder (
    .a   (hi_q),
    .b   (adder_b),
    .c0  (c0),
    .sum (adder_sum),
    .c32 (c32)
  );

  always_comb begin
    adder_b  = add_en ? (b_inv ? ~m_q : m_q) : '0;
    step_sum = add_en ? adder_sum : hi_q;
    // True 33rd sum bit, so an overflowing add still shifts in the right sign.
    sum_msb  = add_en ? (hi_q[WIDTH-1] ^ adder_b[WIDTH-1] ^ c32) : hi_q[WIDTH-1];
    step_prod = {sum_msb, step_sum, lo_q};
  end

`ifdef BOOTH_EARLY_EXIT_EN
  logic [WIDTH:0]   rem_mask, rem_bits;
  logic [2*WIDTH:0] exit_prod;
  always_comb begin
    // Unprocessed multiplier bits are lo[WIDTH-1-cnt:0]; q sits below them.
    rem_mask   = {(WIDTH+1){1'b1}} >> cnt_q;
    rem_bits   = {lo_q, q_q} & rem_mask;
    early_exit = (state_q == ST_RUN) && ((rem_bits == '0) || (rem_bits == rem_mask));
    exit_prod  = $signed({hi_q, lo_q, q_q}) >>> (7'(WIDTH) - 7'(cnt_q));
  end
`else
  assign early_exit = 1'b0;
`endif

  // State and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      q_q      <= 1'b0;
      m_q      <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      q_q      <= q_d;
      m_q      <= m_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (ctrl_MULT) state_d = ST_RUN;
      ST_RUN:  if ((cnt_q == CNT_W'(MULT_STEPS - 1)) || early_exit) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    q_d      = q_q;
    m_d      = m_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ctrl_MULT) begin
          hi_d  = '0;
          lo_d  = data_operandB;
          q_d   = 1'b0;
          m_d   = data_operandA;
          cnt_d = '0;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q + 1'b1;
`ifdef BOOTH_EARLY_EXIT_EN
        if (early_exit) {hi_d, lo_d, q_d} = exit_prod;
        else            {hi_d, lo_d, q_d} = step_prod;
`else
        {hi_d, lo_d, q_d} = step_prod;
`endif
      end
      ST_DONE: begin
        result_d = lo_q;
        exc_d    = (hi_q != {WIDTH{lo_q[WIDTH-1]}});
        rdy_d    = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    data_result    = result_q;
    data_exception = exc_q;
    data_resultRDY = rdy_q;
    busy           = (state_q != ST_IDLE);
    dbg_state      = state_q;
  end

endmodule

// File: tb/tb_booth_multiplier.sv
module tb_booth_multiplier;

  logic        clock;
  logic        reset;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;
  logic [1:0]  dbg_state;

  int checks;
  int errors;
  int cyc;
  logic [31:0] exp_q[$];

  booth_multiplier dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy),
    .dbg_state      (dbg_state)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Driver tasks
  task automatic tick();
    @(negedge clock);
    cyc++;
  endtask

  // Accept edge is "edge 0"; cyc counts negedges after it.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = 1'b1;
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    cyc = 0;
  endtask

  task automatic wait_rdy(output logic ok);
    ok = 1'b0;
    while (!ok && cyc < 100) begin
      tick();
      if (data_resultRDY === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic check_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic exp_exc);
    logic ok;
    start_op(a, b);
    exp_q.push_back(exp_res);
    wait_rdy(ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL %s rdy timeout got=0 want=1", name);
    end
    checks++;
    if (data_result !== exp_q[0]) begin
      errors++;
      $display("FAIL %s result got=%h want=%h", name, data_result, exp_q[0]);
    end
    void'(exp_q.pop_front());
    checks++;
    if (data_exception !== exp_exc) begin
      errors++;
      $display("FAIL %s exception got=%b want=%b", name, data_exception, exp_exc);
    end
`ifndef BOOTH_EARLY_EXIT_EN
    checks++;
    if (cyc !== 33) begin
      errors++;
      $display("FAIL %s latency got=%0d want=33", name, cyc);
    end
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ctrl_MULT = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (2) @(negedge clock);
    checks++;
    if ({data_result, data_exception, data_resultRDY, busy, dbg_state} !== 36'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%h/%b/%b/%b/%0d want=0", data_result, data_exception,
               data_resultRDY, busy, dbg_state);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    check_op("mul_3x5", 32'd3, 32'd5, 32'h0000000F, 1'b0);
    tick();
    checks++;
    if (data_resultRDY !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rdy_pulse rdy=%b busy=%b want rdy=0 busy=0", data_resultRDY, busy);
    end
    checks++;
    if (data_result !== 32'h0000000F) begin
      errors++;
      $display("FAIL result_hold got=%h want=0000000f", data_result);
    end
  endtask

  task automatic test_busy_flag();
    start_op(32'd11, 32'h0000_0F0F);
    checks++;
    if (busy !== 1'b1 || dbg_state !== 2'd1) begin
      errors++;
      $display("FAIL busy_run busy=%b state=%0d want busy=1 state=1", busy, dbg_state);
    end
    begin
      logic ok;
      wait_rdy(ok);
    end
  endtask

  task automatic test_signed();
    check_op("neg7x6", 32'hFFFFFFF9, 32'd6, 32'hFFFFFFD6, 1'b0);
    check_op("6xneg7", 32'd6, 32'hFFFFFFF9, 32'hFFFFFFD6, 1'b0);
    check_op("neg1xneg1", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0);
    check_op("min_x_1", 32'h80000000, 32'd1, 32'h80000000, 1'b0);
  endtask

  task automatic test_overflow();
    check_op("min_x_neg1", 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1);
    check_op("2p16_sq", 32'h00010000, 32'h00010000, 32'h00000000, 1'b1);
    check_op("min_x_min", 32'h80000000, 32'h80000000, 32'h00000000, 1'b1);
    check_op("max_x_2", 32'h7FFFFFFF, 32'd2, 32'hFFFFFFFE, 1'b1);
  endtask

  task automatic test_start_while_busy();
    logic ok;
    int pulse_at;
`ifdef BOOTH_EARLY_EXIT_EN
    pulse_at = 2;
`else
    pulse_at = 10;
`endif
    start_op(32'd2, 32'd3);
    while (cyc < pulse_at) tick();
    data_operandA = 32'd9;
    data_operandB = 32'd9;
    ctrl_MULT = 1'b1;
    tick();
    ctrl_MULT = 1'b0;
    wait_rdy(ok);
    checks++;
    if (ok !== 1'b1 || data_result !== 32'd6) begin
      errors++;
      $display("FAIL busy_ignore rdy=%b result=%h want rdy=1 result=00000006", ok, data_result);
    end
`ifndef BOOTH_EARLY_EXIT_EN
    checks++;
    if (cyc !== 33) begin
      errors++;
      $display("FAIL busy_ignore_latency got=%0d want=33", cyc);
    end
`endif
    check_op("fresh_9x9", 32'd9, 32'd9, 32'h00000051, 1'b0);
  endtask

  task automatic test_reset_mid_run();
    logic rdy_seen;
    int hit_at;
`ifdef BOOTH_EARLY_EXIT_EN
    hit_at = 1;
`else
    hit_at = 12;
`endif
    rdy_seen = 1'b0;
    start_op(32'd5, 32'd5);
    while (cyc < hit_at) begin
      tick();
      if (data_resultRDY === 1'b1) rdy_seen = 1'b1;
    end
    reset = 1'b1;
    #1;
    checks++;
    if (data_result !== 32'd0 || busy !== 1'b0 || data_resultRDY !== 1'b0 || rdy_seen !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_run result=%h busy=%b rdy=%b seen=%b want all 0",
               data_result, busy, data_resultRDY, rdy_seen);
    end
    @(negedge clock);
    reset = 1'b0;
    check_op("after_reset_4xneg2", 32'd4, 32'hFFFFFFFE, 32'hFFFFFFF8, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic ok;
    @(negedge clock);
    data_operandA = 32'd3;
    data_operandB = 32'd7;
    ctrl_MULT = 1'b1;
    cyc = -1;
    wait_rdy(ok);
    checks++;
    if (ok !== 1'b1 || data_result !== 32'd21) begin
      errors++;
      $display("FAIL b2b_first rdy=%b result=%h want rdy=1 result=00000015", ok, data_result);
    end
    // Still high: the next op starts on IDLE entry with these operands.
    data_operandA = 32'd6;
    data_operandB = 32'hFFFFFFFD;
    cyc = 0;
    tick();
    ctrl_MULT = 1'b0;
    wait_rdy(ok);
    checks++;
    if (ok !== 1'b1 || data_result !== 32'hFFFFFFEE || data_exception !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second rdy=%b result=%h exc=%b want rdy=1 result=ffffffee exc=0",
               ok, data_result, data_exception);
    end
`ifndef BOOTH_EARLY_EXIT_EN
    checks++;
    if (cyc !== 34) begin
      errors++;
      $display("FAIL b2b_latency got=%0d want=34", cyc);
    end
`endif
  endtask

`ifdef BOOTH_EARLY_EXIT_EN
  task automatic test_early_exit();
    check_op("early_b0", 32'h12345678, 32'd0, 32'd0, 1'b0);
    checks++;
    if (cyc !== 2) begin
      errors++;
      $display("FAIL early_b0_latency got=%0d want=2", cyc);
    end
    check_op("early_b1", 32'h12345678, 32'd1, 32'h12345678, 1'b0);
    checks++;
    if (cyc >= 33) begin
      errors++;
      $display("FAIL early_b1_latency got=%0d want<33", cyc);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    cyc = 0;
    test_reset();
    test_basic();
    test_busy_flag();
    test_signed();
    test_overflow();
    test_start_while_busy();
    test_reset_mid_run();
    test_back_to_back();
`ifdef BOOTH_EARLY_EXIT_EN
    test_early_exit();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/booth_multiplier.md
Name: booth_multiplier

Overview:
- Sequential 32x32 signed multiplier for the execute stage, sitting beside the ALU.
- Radix-2 Booth, one step per clock; every add/subtract goes through a single instance of two_level_carry_lookahead, the ALU's 32-bit adder.
- Returns the low 32 bits of the product, an overflow exception, and a one-cycle ready pulse to the pipeline stall logic.

Parameters:
- WIDTH, 32, operand/result width; only 32 is supported because the adder is fixed at 32 bits.
- CNT_W, 6, step counter width; must hold WIDTH.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- data_operandA  input  32  multiplicand, signed; sampled only on an accepted start.
- data_operandB  input  32  multiplier, signed; sampled only on an accepted start.
- ctrl_MULT  input  1  start pulse; accepted only in IDLE.
- data_result  output  32  low 32 bits of A*B; held until next accepted start.
- data_exception  output  1  product does not fit in signed 32 bits; held with data_result.
- data_resultRDY  output  1  one-cycle pulse when data_result/data_exception become valid.
- busy  output  1  high in RUN and DONE.

Behaviour:
- Reset (async, any state): state=IDLE; data_result=0, data_exception=0, data_resultRDY=0, busy=0; counter and product register cleared.
- Datapath: product register {hi[31:0], lo[31:0], q}.
  - On start: hi=0, lo=B, q=0, M=A latched.
  - Each RUN cycle selects an adder op from {lo[0],q}:
    - 01: hi+M, adder c0=0.
    - 10: hi+~M, adder c0=1.
    - 00/11: no add; sum=hi.
  - Then arithmetic shift right of the 65-bit {sum_ext, lo, q} by 1.
  - Shifted-in MSB is the true 33rd sum bit, hi[31]^Bop[31]^c32, where Bop is the adder B operand and c32 the adder carry-out. Using sum[31] alone is wrong on add overflow.
  - No-add steps shift in hi[31].
- FSM:
  - IDLE: ctrl_MULT=1 -> load operands, counter=0, go to RUN, busy=1. Otherwise stay.
  - RUN: one Booth step per cycle; counter+1. When counter reaches WIDTH-1 the last step is taken and the FSM goes to DONE.
  - DONE: data_result=lo, data_exception=(hi != {32{lo[31]}}), data_resultRDY=1 for this cycle only. Go to IDLE; busy drops with the transition.
- Latency: start accepted at edge 0; steps at edges 1..32; data_resultRDY high in the cycle after edge 33 (33 cycles start-to-ready). A new start is accepted in the cycle after the RDY pulse.
- Boundary cases:
  - ctrl_MULT high while busy: ignored; operands are not re-sampled.
  - ctrl_MULT held high continuously: a new op starts at each IDLE entry.
  - Operand changes after the start edge have no effect.
  - A=0x80000000 and/or B=0x80000000: handled exactly; the 33-bit sign rule covers M=-2^31 subtraction.
  - Reset mid-RUN: op is aborted with no RDY pulse; next start is accepted on the first edge after reset deasserts.
  - data_result/data_exception change only in DONE or on reset.

Optional Feature:
- Macro BOOTH_EARLY_EXIT_EN.
- Defined: in RUN, if the unprocessed multiplier bits plus q are all equal (all 0s or all 1s), the remaining steps are shift-only. They are completed in that cycle by a single arithmetic shift of (WIDTH - counter) positions, then the FSM goes to DONE. Latency is then variable, minimum 2 cycles start-to-RDY (e.g. B=0 or B=-1).
- Not defined: fixed 33-cycle latency with no barrel shifter.
- Results and exceptions are identical either way.

Decomposition:
- Shared package/header holds:
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - Booth op encodings OP_NOP, OP_ADD, OP_SUB.
  - MULT_WIDTH=32, MULT_STEPS=32.
- Sub-module booth_step_decode: combinational; maps {lo[0],q} to the adder B-operand select, c0 and an add_en flag.
- The adder is an instance of two_level_carry_lookahead, not re-implemented.

Test Plan:
- A=3, B=5, start pulse -> after 33 cycles data_result=0x0000000F, exception=0, RDY high exactly 1 cycle, busy=0 next cycle.
- A=-7 (0xFFFFFFF9), B=6 -> data_result=0xFFFFFFD6, exception=0; swap operands -> same result.
- A=0x80000000, B=0xFFFFFFFF -> data_result=0x80000000, exception=1; A=0x00010000, B=0x00010000 -> data_result=0, exception=1.
- Start A=2, B=3, pulse ctrl_MULT with A=9, B=9 at cycle 10 -> ignored, result=6 at cycle 33, then a fresh start is accepted.
- Start A=5, B=5, assert reset at cycle 12 for 1 cycle -> outputs 0 immediately, no RDY; start A=4, B=-2 next -> data_result=0xFFFFFFF8.
- With BOOTH_EARLY_EXIT_EN: B=0 -> RDY 2 cycles after start, result 0; B=1, A=0x12345678 -> result 0x12345678 in fewer than 33 cycles, exception=0.
